mem_port_arbiter: RTL and testbench

- Shares one downstream memory port between the instruction-fetch channel and the data-memory channel of the pipelined custom CPU.
- Arbitrates requests and holds each grant until the downstream accepts it.
- Tracks outstanding reads in an in-order owner FIFO and routes each read response back to the requester that issued it.
- Sits between the CPU core's Inst/Mem channels and the single-ported memory/cache interface.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between the fetch and data channels, routing read
// responses back in order. Define ARB_CONFLICT_CNT_EN to enable the conflict-cycle counter.
module mem_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    output logic [31:0]       i_rsp_data,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_wen,
    input  logic              d_req_ren,
    input  logic [31:0]       d_req_wdata,
    input  logic [3:0]        d_req_wstrb,
    output logic              d_req_ready,
    output logic [31:0]       d_rsp_data,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wen,
    output logic              m_ren,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_req_ready,
    input  logic [31:0]       m_rsp_data,
    input  logic              m_rsp_valid,
    output logic              m_rsp_ready,
    output logic [31:0]       arb_conflict_cnt
);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I} state_t;

    state_t                     state;
    logic [MAX_OUTSTANDING-1:0] owner_mem;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       d_pend;
    logic                       room;
    logic                       d_win;
    logic                       i_win;
    logic                       hs;
    logic                       push;
    logic                       pop;
    logic                       fifo_empty;
    logic                       head_d;

    assign d_pend     = d_req_wen | d_req_ren;
    assign room       = (count < CNT_W'(MAX_OUTSTANDING));
    // Writes never occupy a FIFO slot, so only reads wait for room.
    assign d_win      = d_pend & (d_req_wen | room);
    assign i_win      = i_req_valid & room;
    assign hs         = (m_wen | m_ren) & m_req_ready;
    assign push       = hs & m_ren;
    assign fifo_empty = (count == '0);
    assign head_d     = owner_mem[rd_ptr];

    always_comb begin
        m_addr      = '0;
        m_wen       = 1'b0;
        m_ren       = 1'b0;
        m_wdata     = '0;
        m_wstrb     = '0;
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        case (state)
            GRANT_D: begin
                m_addr      = d_req_addr;
                m_wen       = d_req_wen;
                m_ren       = d_req_ren;
                m_wdata     = d_req_wdata;
                m_wstrb     = d_req_wstrb;
                d_req_ready = m_req_ready;
            end
            GRANT_I: begin
                m_addr      = i_req_addr;
                m_ren       = 1'b1;
                i_req_ready = m_req_ready;
            end
            default: ;
        endcase
    end

    assign m_rsp_ready = ~fifo_empty & (head_d ? d_rsp_ready : i_rsp_ready);
    assign pop         = m_rsp_valid & m_rsp_ready;
    assign i_rsp_valid = m_rsp_valid & ~fifo_empty & ~head_d;
    assign d_rsp_valid = m_rsp_valid & ~fifo_empty & head_d;
    assign i_rsp_data  = m_rsp_data;
    assign d_rsp_data  = m_rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_win)
                        state <= GRANT_D;
                    else if (i_win)
                        state <= GRANT_I;
                end
                GRANT_D, GRANT_I: begin
                    if (hs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (push) begin
                owner_mem[wr_ptr] <= (state == GRANT_D);
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef ARB_CONFLICT_CNT_EN
    logic [31:0] conflict_q;

    always_ff @(posedge clk) begin
        if (rst)
            conflict_q <= '0;
        else if ((state == IDLE) && d_win && i_req_valid)
            conflict_q <= conflict_q + 32'd1;
    end

    assign arb_conflict_cnt = conflict_q;
`else
    assign arb_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grants and the read-owner queue.
module tb_mem_port_arbiter;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned AW      = 32;
`ifdef ARB_CONFLICT_CNT_EN
    localparam bit CONF_EN = 1'b1;
`else
    localparam bit CONF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_req_addr;
    logic          i_req_valid;
    logic          i_req_ready;
    logic [31:0]   i_rsp_data;
    logic          i_rsp_valid;
    logic          i_rsp_ready;
    logic [AW-1:0] d_req_addr;
    logic          d_req_wen;
    logic          d_req_ren;
    logic [31:0]   d_req_wdata;
    logic [3:0]    d_req_wstrb;
    logic          d_req_ready;
    logic [31:0]   d_rsp_data;
    logic          d_rsp_valid;
    logic          d_rsp_ready;
    logic [AW-1:0] m_addr;
    logic          m_wen;
    logic          m_ren;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_req_ready;
    logic [31:0]   m_rsp_data;
    logic          m_rsp_valid;
    logic          m_rsp_ready;
    logic [31:0]   arb_conflict_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_conf;

    mem_port_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req_addr(i_req_addr), .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
        .i_rsp_data(i_rsp_data), .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .d_req_addr(d_req_addr), .d_req_wen(d_req_wen), .d_req_ren(d_req_ren),
        .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
        .d_rsp_data(d_rsp_data), .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .m_addr(m_addr), .m_wen(m_wen), .m_ren(m_ren), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_req_ready(m_req_ready), .m_rsp_data(m_rsp_data), .m_rsp_valid(m_rsp_valid),
        .m_rsp_ready(m_rsp_ready), .arb_conflict_cnt(arb_conflict_cnt)
    );

    always #5 clk = ~clk;

    // The core never raises both data strobes at once.
    always @(negedge clk) begin
        if (d_req_wen && d_req_ren) begin
            $display("FAIL wen_ren_exclusive got wen=1 ren=1 required at most one");
            n_err++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout required $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req_valid = 1'b0; i_req_addr = '0; i_rsp_ready = 1'b0;
        d_req_addr = '0; d_req_wen = 1'b0; d_req_ren = 1'b0;
        d_req_wdata = '0; d_req_wstrb = '0; d_rsp_ready = 1'b0;
        m_req_ready = 1'b0; m_rsp_data = '0; m_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_conf = '0;
        m_rsp_valid = 1'b1; m_rsp_data = 32'hCAFE0000;
        i_rsp_ready = 1'b1; d_rsp_ready = 1'b1; m_req_ready = 1'b1;
        #2;
        n_vec++; if (i_req_ready !== 1'b0) begin $display("FAIL rst_i_req_ready got %b required 0", i_req_ready); n_err++; end
        n_vec++; if (d_req_ready !== 1'b0) begin $display("FAIL rst_d_req_ready got %b required 0", d_req_ready); n_err++; end
        n_vec++; if (m_wen !== 1'b0 || m_ren !== 1'b0) begin $display("FAIL rst_m_wen_ren got %b%b required 00", m_wen, m_ren); n_err++; end
        n_vec++; if (i_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin $display("FAIL rst_rsp_valid got %b%b required 00", i_rsp_valid, d_rsp_valid); n_err++; end
        n_vec++; if (m_rsp_ready !== 1'b0) begin $display("FAIL rst_m_rsp_ready got %b required 0", m_rsp_ready); n_err++; end
        n_vec++; if (arb_conflict_cnt !== 32'd0) begin $display("FAIL rst_conflict_cnt got %0d required 0", arb_conflict_cnt); n_err++; end
        idle_inputs();
    endtask

    task automatic test_single_fetch();
        tick();
        i_req_valid = 1'b1; i_req_addr = 32'h100; m_req_ready = 1'b1;
        i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        #2;
        n_vec++; if (m_ren !== 1'b0 || i_req_ready !== 1'b0) begin $display("FAIL sf_idle got ren=%b rdy=%b required 0 0", m_ren, i_req_ready); n_err++; end
        tick();
        #2;
        n_vec++; if (m_ren !== 1'b1 || m_addr !== 32'h100) begin $display("FAIL sf_grant got ren=%b addr=%h required 1 00000100", m_ren, m_addr); n_err++; end
        n_vec++; if (i_req_ready !== 1'b1) begin $display("FAIL sf_i_req_ready got %b required 1", i_req_ready); n_err++; end
        tick();
        i_req_valid = 1'b0; m_rsp_valid = 1'b1; m_rsp_data = 32'h00000013;
        #2;
        n_vec++; if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'h13) begin $display("FAIL sf_rsp got v=%b d=%h required 1 00000013", i_rsp_valid, i_rsp_data); n_err++; end
        n_vec++; if (d_rsp_valid !== 1'b0) begin $display("FAIL sf_d_rsp_valid got %b required 0", d_rsp_valid); n_err++; end
        n_vec++; if (m_rsp_ready !== 1'b1) begin $display("FAIL sf_m_rsp_ready got %b required 1", m_rsp_ready); n_err++; end
        tick();
        m_rsp_valid = 1'b0;
        #2;
        n_vec++; if (m_rsp_ready !== 1'b0) begin $display("FAIL sf_empty_after got m_rsp_ready=%b required 0", m_rsp_ready); n_err++; end
        idle_inputs();
    endtask

    task automatic test_priority();
        tick();
        i_req_valid = 1'b1; i_req_addr = 32'h200;
        d_req_ren = 1'b1; d_req_addr = 32'h300;
        m_req_ready = 1'b1; i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        #2;
        if (CONF_EN) exp_conf++;
        n_vec++; if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin $display("FAIL pr_idle got i=%b d=%b required 0 0", i_req_ready, d_req_ready); n_err++; end
        tick();
        #2;
        n_vec++; if (m_addr !== 32'h300 || m_ren !== 1'b1 || m_wen !== 1'b0) begin $display("FAIL pr_d_grant got addr=%h ren=%b wen=%b required 00000300 1 0", m_addr, m_ren, m_wen); n_err++; end
        n_vec++; if (d_req_ready !== 1'b1 || i_req_ready !== 1'b0) begin $display("FAIL pr_d_ready got d=%b i=%b required 1 0", d_req_ready, i_req_ready); n_err++; end
        tick();
        d_req_ren = 1'b0;
        #2;
        n_vec++; if (i_req_ready !== 1'b0 || m_ren !== 1'b0) begin $display("FAIL pr_gap got i=%b ren=%b required 0 0", i_req_ready, m_ren); n_err++; end
        tick();
        #2;
        n_vec++; if (m_addr !== 32'h200 || m_ren !== 1'b1 || i_req_ready !== 1'b1) begin $display("FAIL pr_i_grant got addr=%h ren=%b rdy=%b required 00000200 1 1", m_addr, m_ren, i_req_ready); n_err++; end
        tick();
        i_req_valid = 1'b0; m_rsp_valid = 1'b1; m_rsp_data = 32'hAAAA0001;
        #2;
        n_vec++; if (d_rsp_valid !== 1'b1 || i_rsp_valid !== 1'b0 || d_rsp_data !== 32'hAAAA0001) begin $display("FAIL pr_rsp_d got dv=%b iv=%b d=%h required 1 0 aaaa0001", d_rsp_valid, i_rsp_valid, d_rsp_data); n_err++; end
        tick();
        m_rsp_data = 32'hBBBB0002;
        #2;
        n_vec++; if (i_rsp_valid !== 1'b1 || d_rsp_valid !== 1'b0 || i_rsp_data !== 32'hBBBB0002) begin $display("FAIL pr_rsp_i got iv=%b dv=%b d=%h required 1 0 bbbb0002", i_rsp_valid, d_rsp_valid, i_rsp_data); n_err++; end
        tick();
        m_rsp_valid = 1'b0;
        #2;
        n_vec++; if (arb_conflict_cnt !== exp_conf) begin $display("FAIL pr_conflict_cnt got %0d required %0d", arb_conflict_cnt, exp_conf); n_err++; end
        n_vec++; if (m_rsp_ready !== 1'b0) begin $display("FAIL pr_empty got m_rsp_ready=%b required 0", m_rsp_ready); n_err++; end
        idle_inputs();
    endtask

    task automatic test_write_stall();
        logic exp_rdy;
        tick();
        d_req_wen = 1'b1; d_req_addr = 32'h400; d_req_wdata = 32'hDEADBEEF; d_req_wstrb = 4'hF;
        m_req_ready = 1'b0; i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        #2;
        n_vec++; if (d_req_ready !== 1'b0) begin $display("FAIL ws_idle got d_req_ready=%b required 0", d_req_ready); n_err++; end
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_rdy = (k == 3);
            m_req_ready = exp_rdy;
            #2;
            n_vec++; if (m_wen !== 1'b1 || m_ren !== 1'b0) begin $display("FAIL ws_wen cyc=%0d got wen=%b ren=%b required 1 0", k, m_wen, m_ren); n_err++; end
            n_vec++; if (m_addr !== 32'h400 || m_wdata !== 32'hDEADBEEF || m_wstrb !== 4'hF) begin $display("FAIL ws_fields cyc=%0d got %h %h %h required 00000400 deadbeef f", k, m_addr, m_wdata, m_wstrb); n_err++; end
            n_vec++; if (d_req_ready !== exp_rdy) begin $display("FAIL ws_ready cyc=%0d got %b required %b", k, d_req_ready, exp_rdy); n_err++; end
        end
        tick();
        d_req_wen = 1'b0; m_req_ready = 1'b1;
        #2;
        n_vec++; if (m_wen !== 1'b0 || d_req_ready !== 1'b0) begin $display("FAIL ws_release got wen=%b rdy=%b required 0 0", m_wen, d_req_ready); n_err++; end
        n_vec++; if (m_rsp_ready !== 1'b0) begin $display("FAIL ws_no_push got m_rsp_ready=%b required 0", m_rsp_ready); n_err++; end
        idle_inputs();
    endtask

    task automatic test_full_stall();
        tick();
        m_req_ready = 1'b1; i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_req_valid = 1'b1; i_req_addr = 32'h1000 + 32'(4 * k);
            tick();
            #2;
            n_vec++; if (i_req_ready !== 1'b1 || m_addr !== 32'h1000 + 32'(4 * k)) begin $display("FAIL fs_fill k=%0d got rdy=%b addr=%h required 1 %h", k, i_req_ready, m_addr, 32'h1000 + 32'(4 * k)); n_err++; end
            tick();
        end
        i_req_addr = 32'h1010;
        for (int k = 0; k < 3; k++) begin
            #2;
            n_vec++; if (i_req_ready !== 1'b0 || m_ren !== 1'b0) begin $display("FAIL fs_stall k=%0d got rdy=%b ren=%b required 0 0", k, i_req_ready, m_ren); n_err++; end
            tick();
        end
        d_req_wen = 1'b1; d_req_addr = 32'h500; d_req_wdata = 32'h11223344; d_req_wstrb = 4'h3;
        if (CONF_EN) exp_conf++;
        tick();
        #2;
        n_vec++; if (m_wen !== 1'b1 || d_req_ready !== 1'b1 || i_req_ready !== 1'b0) begin $display("FAIL fs_write got wen=%b drdy=%b irdy=%b required 1 1 0", m_wen, d_req_ready, i_req_ready); n_err++; end
        tick();
        d_req_wen = 1'b0;
        #2;
        n_vec++; if (i_req_ready !== 1'b0 || m_ren !== 1'b0) begin $display("FAIL fs_still_full got rdy=%b ren=%b required 0 0", i_req_ready, m_ren); n_err++; end
        tick();
        m_rsp_valid = 1'b1; m_rsp_data = 32'h00005000;
        #2;
        n_vec++; if (i_rsp_valid !== 1'b1 || m_rsp_ready !== 1'b1) begin $display("FAIL fs_pop got iv=%b mrr=%b required 1 1", i_rsp_valid, m_rsp_ready); n_err++; end
        tick();
        m_rsp_valid = 1'b0;
        #2;
        n_vec++; if (i_req_ready !== 1'b0) begin $display("FAIL fs_arb_cycle got rdy=%b required 0", i_req_ready); n_err++; end
        tick();
        #2;
        n_vec++; if (m_ren !== 1'b1 || m_addr !== 32'h1010 || i_req_ready !== 1'b1) begin $display("FAIL fs_regrant got ren=%b addr=%h rdy=%b required 1 00001010 1", m_ren, m_addr, i_req_ready); n_err++; end
        tick();
        i_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_rsp_valid = 1'b1; m_rsp_data = 32'h00006000 + 32'(k);
            #2;
            n_vec++; if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'h00006000 + 32'(k)) begin $display("FAIL fs_drain k=%0d got v=%b d=%h required 1 %h", k, i_rsp_valid, i_rsp_data, 32'h00006000 + 32'(k)); n_err++; end
            tick();
        end
        m_rsp_valid = 1'b0;
        #2;
        n_vec++; if (m_rsp_ready !== 1'b0) begin $display("FAIL fs_empty got m_rsp_ready=%b required 0", m_rsp_ready); n_err++; end
        n_vec++; if (arb_conflict_cnt !== exp_conf) begin $display("FAIL fs_conflict_cnt got %0d required %0d", arb_conflict_cnt, exp_conf); n_err++; end
        idle_inputs();
    endtask

    task automatic test_rsp_backpressure();
        tick();
        m_req_ready = 1'b1; i_rsp_ready = 1'b1; d_rsp_ready = 1'b0;
        d_req_ren = 1'b1; d_req_addr = 32'h600;
        tick();
        tick();
        d_req_ren = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 32'h700;
        tick();
        tick();
        i_req_valid = 1'b0;
        m_rsp_valid = 1'b1; m_rsp_data = 32'h12345678;
        for (int k = 0; k < 2; k++) begin
            #2;
            n_vec++; if (m_rsp_ready !== 1'b0) begin $display("FAIL bp_hold k=%0d got m_rsp_ready=%b required 0", k, m_rsp_ready); n_err++; end
            n_vec++; if (d_rsp_valid !== 1'b1 || i_rsp_valid !== 1'b0) begin $display("FAIL bp_head k=%0d got dv=%b iv=%b required 1 0", k, d_rsp_valid, i_rsp_valid); n_err++; end
            tick();
        end
        d_rsp_ready = 1'b1;
        #2;
        n_vec++; if (m_rsp_ready !== 1'b1 || d_rsp_data !== 32'h12345678) begin $display("FAIL bp_accept got mrr=%b d=%h required 1 12345678", m_rsp_ready, d_rsp_data); n_err++; end
        tick();
        m_rsp_data = 32'h87654321;
        #2;
        n_vec++; if (i_rsp_valid !== 1'b1 || d_rsp_valid !== 1'b0) begin $display("FAIL bp_next_head got iv=%b dv=%b required 1 0", i_rsp_valid, d_rsp_valid); n_err++; end
        tick();
        m_rsp_valid = 1'b0;
        #2;
        n_vec++; if (m_rsp_ready !== 1'b0) begin $display("FAIL bp_empty got m_rsp_ready=%b required 0", m_rsp_ready); n_err++; end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        tick();
        m_req_ready = 1'b1; i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_req_valid = 1'b1; i_req_addr = 32'h800 + 32'(4 * k);
            tick();
            tick();
        end
        i_req_valid = 1'b0; m_req_ready = 1'b0;
        d_req_wen = 1'b1; d_req_addr = 32'h900; d_req_wdata = 32'h0F0F0F0F; d_req_wstrb = 4'hC;
        tick();
        #2;
        n_vec++; if (m_wen !== 1'b1) begin $display("FAIL rm_in_grant got m_wen=%b required 1", m_wen); n_err++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_conf = '0;
        m_rsp_valid = 1'b1; m_rsp_data = 32'hBAD0BAD0;
        #2;
        n_vec++; if (m_wen !== 1'b0 || m_ren !== 1'b0) begin $display("FAIL rm_idle got wen=%b ren=%b required 0 0", m_wen, m_ren); n_err++; end
        n_vec++; if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin $display("FAIL rm_req_ready got i=%b d=%b required 0 0", i_req_ready, d_req_ready); n_err++; end
        n_vec++; if (i_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 || m_rsp_ready !== 1'b0) begin $display("FAIL rm_fifo_cleared got iv=%b dv=%b mrr=%b required 0 0 0", i_rsp_valid, d_rsp_valid, m_rsp_ready); n_err++; end
        n_vec++; if (arb_conflict_cnt !== 32'd0) begin $display("FAIL rm_conflict_cnt got %0d required 0", arb_conflict_cnt); n_err++; end
        idle_inputs();
    endtask

    // Model: grant holder (0 none, 1 fetch, 2 data) and a queue of read owners (1 = data).
    task automatic test_random(input int unsigned cycles);
        int unsigned grant;
        int unsigned grant_old;
        bit          q[$];
        bit          hs, rd, pop, room, head;
        logic        e_irdy, e_drdy, e_ren, e_wen, e_iv, e_dv, e_mrr;
        logic [31:0] e_addr;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_conf = '0;
        grant = 0;
        for (int unsigned c = 0; c < cycles; c++) begin
            if (!i_req_valid && $urandom_range(0, 2) == 0) begin
                i_req_valid = 1'b1; i_req_addr = $urandom;
            end
            if (!d_req_wen && !d_req_ren && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) d_req_wen = 1'b1;
                else d_req_ren = 1'b1;
                d_req_addr = $urandom; d_req_wdata = $urandom; d_req_wstrb = 4'($urandom);
            end
            m_req_ready = ($urandom_range(0, 3) != 0);
            if (!m_rsp_valid && q.size() > 0 && $urandom_range(0, 1) == 1) begin
                m_rsp_valid = 1'b1; m_rsp_data = $urandom;
            end
            i_rsp_ready = ($urandom_range(0, 3) != 0);
            d_rsp_ready = ($urandom_range(0, 3) != 0);
            #2;
            e_irdy = (grant == 1) && m_req_ready;
            e_drdy = (grant == 2) && m_req_ready;
            e_ren  = (grant == 1) || ((grant == 2) && d_req_ren);
            e_wen  = (grant == 2) && d_req_wen;
            e_addr = (grant == 1) ? i_req_addr : d_req_addr;
            head   = (q.size() > 0) ? q[0] : 1'b0;
            e_iv   = m_rsp_valid && (q.size() > 0) && !head;
            e_dv   = m_rsp_valid && (q.size() > 0) && head;
            e_mrr  = (q.size() > 0) && (head ? d_rsp_ready : i_rsp_ready);
            n_vec++; if (i_req_ready !== e_irdy) begin $display("FAIL rnd_i_req_ready cyc=%0d got %b required %b", c, i_req_ready, e_irdy); n_err++; end
            n_vec++; if (d_req_ready !== e_drdy) begin $display("FAIL rnd_d_req_ready cyc=%0d got %b required %b", c, d_req_ready, e_drdy); n_err++; end
            n_vec++; if (m_ren !== e_ren || m_wen !== e_wen) begin $display("FAIL rnd_m_cmd cyc=%0d got ren=%b wen=%b required %b %b", c, m_ren, m_wen, e_ren, e_wen); n_err++; end
            if (grant != 0) begin
                n_vec++; if (m_addr !== e_addr) begin $display("FAIL rnd_m_addr cyc=%0d got %h required %h", c, m_addr, e_addr); n_err++; end
            end
            if (e_wen) begin
                n_vec++; if (m_wdata !== d_req_wdata || m_wstrb !== d_req_wstrb) begin $display("FAIL rnd_m_wdata cyc=%0d got %h/%h required %h/%h", c, m_wdata, m_wstrb, d_req_wdata, d_req_wstrb); n_err++; end
            end
            n_vec++; if (i_rsp_valid !== e_iv || d_rsp_valid !== e_dv) begin $display("FAIL rnd_rsp_valid cyc=%0d got iv=%b dv=%b required %b %b", c, i_rsp_valid, d_rsp_valid, e_iv, e_dv); n_err++; end
            n_vec++; if (m_rsp_ready !== e_mrr) begin $display("FAIL rnd_m_rsp_ready cyc=%0d got %b required %b", c, m_rsp_ready, e_mrr); n_err++; end
            if (e_iv) begin
                n_vec++; if (i_rsp_data !== m_rsp_data) begin $display("FAIL rnd_i_rsp_data cyc=%0d got %h required %h", c, i_rsp_data, m_rsp_data); n_err++; end
            end
            if (e_dv) begin
                n_vec++; if (d_rsp_data !== m_rsp_data) begin $display("FAIL rnd_d_rsp_data cyc=%0d got %h required %h", c, d_rsp_data, m_rsp_data); n_err++; end
            end
            grant_old = grant;
            hs   = (grant != 0) && m_req_ready;
            rd   = hs && ((grant == 1) || d_req_ren);
            pop  = m_rsp_valid && e_mrr;
            room = (q.size() < MAX_OUT);
            if (grant == 0) begin
                if ((d_req_wen || d_req_ren) && (d_req_wen || room)) begin
                    grant = 2;
                    if (CONF_EN && i_req_valid) exp_conf++;
                end else if (i_req_valid && room) begin
                    grant = 1;
                end
            end else if (hs) begin
                grant = 0;
            end
            if (pop) void'(q.pop_front());
            if (rd) q.push_back(grant_old == 2);
            tick();
            if (hs && grant_old == 1) i_req_valid = 1'b0;
            if (hs && grant_old == 2) begin d_req_wen = 1'b0; d_req_ren = 1'b0; end
            if (pop) m_rsp_valid = 1'b0;
        end
        #2;
        n_vec++; if (arb_conflict_cnt !== exp_conf) begin $display("FAIL rnd_conflict_cnt got %0d required %0d", arb_conflict_cnt, exp_conf); n_err++; end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        exp_conf = '0;
        test_reset();
        test_single_fetch();
        test_priority();
        test_write_stall();
        test_full_stall();
        test_rsp_backpressure();
        test_reset_mid();
        test_random(1500);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
